// File: rtl/event_priority_encoder.sv
// event_priority_encoder: captures request-line rises into a pending set and hands out one binary code per Valid/Ack handshake.
// Optional ROTATE_PRIORITY_EN: rotating priority that scans down from the last retired index.
module event_priority_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Enable,
  input  logic         Clear,
  input  logic [N-1:0] D,
  input  logic         Ack,
  output logic [W-1:0] Y,
  output logic         Valid,
  output logic         Any,
  output logic         Overflow
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state_q, state_d;
  logic [N-1:0] d_q, pending_q, pending_d, rise, set, retire;
  logic [W-1:0] y_q, y_d, sel;
  logic valid_q, valid_d, overflow_q, overflow_d, take;
  assign rise = D & ~d_q;
  assign set = rise & {N{Enable}};
  assign take = valid_q && Ack;
  assign retire = take ? {{(N-1){1'b0}}, 1'b1} << y_q : '0;
`ifdef ROTATE_PRIORITY_EN
  logic [W-1:0] last_q, last_d;
  int idx;
  logic found;
  always_comb begin
    sel = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last_q) + N - i) % N;
      if (!found && pending_q[idx]) begin
        sel = W'(idx);
        found = 1'b1;
      end
    end
  end
  assign last_d = Clear ? '0 : take ? y_q : last_q;
`else
  // ascending scan so the highest pending index is the one left in sel
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) if (pending_q[i]) sel = W'(i);
  end
`endif
  always_comb begin
    pending_d = Clear ? '0 : (pending_q & ~retire) | set;
    overflow_d = Clear ? 1'b0 : overflow_q | (|(set & pending_q & ~retire));
    state_d = state_q;
    y_d = y_q;
    valid_d = valid_q;
    if (state_q == IDLE && |pending_q) begin
      state_d = PRESENT;
      y_d = sel;
      valid_d = 1'b1;
    end else if (state_q == PRESENT && Ack) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
    if (Clear) begin
      state_d = IDLE;
      y_d = '0;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      d_q <= '0;
      pending_q <= '0;
      overflow_q <= 1'b0;
      state_q <= IDLE;
      y_q <= '0;
      valid_q <= 1'b0;
`ifdef ROTATE_PRIORITY_EN
      last_q <= '0;
`endif
    end else begin
      d_q <= D;
      pending_q <= pending_d;
      overflow_q <= overflow_d;
      state_q <= state_d;
      y_q <= y_d;
      valid_q <= valid_d;
`ifdef ROTATE_PRIORITY_EN
      last_q <= last_d;
`endif
    end
  end
  assign Y = y_q;
  assign Valid = valid_q;
  assign Any = |pending_q;
  assign Overflow = overflow_q;
endmodule

// File: tb/tb_event_priority_encoder.sv
// tb_event_priority_encoder: directed stimulus with a per-cycle reference model plus literal spot checks.
module tb_event_priority_encoder;
  localparam int N = 8;
  localparam int W = 3;
  logic Clock = 1'b0, Resetn = 1'b0, Enable = 1'b1, Clear = 1'b0, Ack = 1'b0;
  logic [N-1:0] D = '0;
  logic [W-1:0] Y;
  logic Valid, Any, Overflow;
  int tests = 0, fails = 0;
  bit [N-1:0] m_d = '0, m_pend = '0, m_next;
  bit m_valid = 0, m_ovf = 0;
  int m_y = 0, m_last = 0;

  event_priority_encoder #(.N(N), .W(W)) dut (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable), .Clear(Clear), .D(D),
    .Ack(Ack), .Y(Y), .Valid(Valid), .Any(Any), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  function automatic int pick(bit [N-1:0] p, int last);
`ifdef ROTATE_PRIORITY_EN
    for (int k = 1; k <= N; k++) if (p[(last - k + 2 * N) % N]) return (last - k + 2 * N) % N;
`else
    for (int k = N - 1; k >= 0; k--) if (p[k]) return k;
`endif
    return 0;
  endfunction

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_d = '0; m_pend = '0; m_valid = 0; m_ovf = 0; m_y = 0; m_last = 0;
    end else if (Clear) begin
      m_d = D; m_pend = '0; m_valid = 0; m_ovf = 0; m_y = 0; m_last = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        bit r, ret;
        r = D[i] && !m_d[i] && Enable;
        ret = m_valid && Ack && (i == m_y);
        if (r && m_pend[i] && !ret) m_ovf = 1;
        m_next[i] = r || (m_pend[i] && !ret);
      end
      if (!m_valid) begin
        if (m_pend != 0) begin
          m_y = pick(m_pend, m_last);
          m_valid = 1;
        end
      end else if (Ack) begin
        m_valid = 0;
        m_last = m_y;
      end
      m_pend = m_next;
      m_d = D;
    end
  end

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(string name, int act, int model, int exp);
    chk({name, "_dut"}, act, exp);
    chk({name, "_model"}, model, exp);
  endtask

  always @(negedge Clock) begin
    chk("valid", int'(Valid), int'(m_valid));
    chk("any", int'(Any), int'(|m_pend));
    chk("overflow", int'(Overflow), int'(m_ovf));
    if (m_valid) chk("y", int'(Y), m_y);
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  initial begin
    #7;
    lit("rst_valid", Valid, m_valid, 0);
    lit("rst_any", Any, m_pend != 0, 0);
    lit("rst_ovf", Overflow, m_ovf, 0);
    chk("rst_y", Y, 0);
    Resetn = 1'b1;
    D = 8'h20; tick;
    lit("t1_any", Any, m_pend != 0, 1);
    lit("t1_valid0", Valid, m_valid, 0);
    tick;
    lit("t1_valid", Valid, m_valid, 1);
    lit("t1_y", Y, m_y, 5);
    Ack = 1'b1; tick;
    lit("t1_done", Valid, m_valid, 0);
    lit("t1_any0", Any, m_pend != 0, 0);
    Ack = 1'b0; D = 8'h00; tick;
    D = 8'h91; tick; tick;
    lit("t2_y7", Y, m_y, 7);
    Ack = 1'b1; tick;
    lit("t2_gap1", Valid, m_valid, 0);
    tick;
    lit("t2_y4", Y, m_y, 4);
    lit("t2_v4", Valid, m_valid, 1);
    tick;
    lit("t2_gap2", Valid, m_valid, 0);
    tick;
    lit("t2_y0", Y, m_y, 0);
    lit("t2_v0", Valid, m_valid, 1);
    tick;
    lit("t2_end", Any, m_pend != 0, 0);
    Ack = 1'b0; D = 8'h00; tick;
    D = 8'h04; tick; tick;
    lit("t3_y2", Y, m_y, 2);
    D = 8'h00; tick;
    D = 8'h04; tick;
    lit("t3_ovf", Overflow, m_ovf, 1);
    lit("t3_hold", Y, m_y, 2);
    Clear = 1'b1; tick;
    Clear = 1'b0;
    lit("t3_clr", Overflow, m_ovf, 0);
    D = 8'h00; tick;
    D = 8'h04; tick; tick;
    lit("t3_y2b", Y, m_y, 2);
    D = 8'h00; tick;
    D = 8'h04; Ack = 1'b1; tick;
    lit("t3_keep", Any, m_pend != 0, 1);
    lit("t3_noovf", Overflow, m_ovf, 0);
    Ack = 1'b0; D = 8'h00; tick;
    lit("t3_again", Y, m_y, 2);
    Ack = 1'b1; tick;
    Ack = 1'b0; Enable = 1'b0; D = 8'hFF; tick(3);
    lit("t4_any", Any, m_pend != 0, 0);
    lit("t4_valid", Valid, m_valid, 0);
    Enable = 1'b1; tick(2);
    lit("t4_nocap", Any, m_pend != 0, 0);
    D = 8'h00; tick;
    D = 8'h0C; tick; tick;
    lit("t5_y3", Y, m_y, 3);
    Clear = 1'b1; Ack = 1'b1; tick;
    Clear = 1'b0; Ack = 1'b0;
    lit("t5_any", Any, m_pend != 0, 0);
    lit("t5_valid", Valid, m_valid, 0);
    chk("t5_y", Y, 0);
    D = 8'h00; tick;
    D = 8'h08; tick; tick;
    lit("t5_pres", Valid, m_valid, 1);
    #2 Resetn = 1'b0;
    #1;
    chk("t5_rst_valid", Valid, 0);
    chk("t5_rst_y", Y, 0);
    chk("t5_rst_any", Any, 0);
    chk("t5_rst_ovf", Overflow, 0);
    tick;
    D = 8'h00; Resetn = 1'b1; tick;
    D = 8'h81; tick; tick;
    lit("t6_y7", Y, m_y, 7);
    Ack = 1'b1; tick;
    Ack = 1'b0; tick;
    lit("t6_y0", Y, m_y, 0);
    Ack = 1'b1; tick;
    Ack = 1'b0; D = 8'h01; tick;
    D = 8'h81; tick; tick;
    lit("t6_y7b", Y, m_y, 7);
    Ack = 1'b1; tick;
    Ack = 1'b0; tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
